// File: rtl/popcount_frame_acc_pkg.sv
// Shared widths and sizing helpers for the popcount frame accumulator.
package popcount_frame_acc_pkg;

    localparam int WORD_W      = 7;
    localparam int PC_W        = 3;
    localparam int OUT_WORDS_W = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/popcount_frame_acc_onescount.sv
// 7-bit combinational ones counter.
module popcount_frame_acc_onescount
    import popcount_frame_acc_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    output logic [PC_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WORD_W; i++) begin
            count = count + PC_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_frame_acc.sv
// Frame accumulator of per-word ones counts with saturation,
// forced close after MAX_WORDS and a single-entry output buffer.
module popcount_frame_acc
    import popcount_frame_acc_pkg::*;
#(
    parameter int MAX_WORDS = 16,
    parameter int ACC_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_count,
    output logic [OUT_WORDS_W-1:0] out_words,
    output logic                   out_overflow
);

    localparam int WCNT_W = clog2(MAX_WORDS + 1);
    localparam logic [ACC_W:0] SAT_MAX = {1'b0, {ACC_W{1'b1}}};
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(MAX_WORDS - 1);

    if (MAX_WORDS < 1 || MAX_WORDS > 255) begin : g_bad_max
        $error("MAX_WORDS must be in 1..255");
    end
    if (ACC_W < 3) begin : g_bad_acc
        $error("ACC_W must be at least 3");
    end

    logic [ACC_W-1:0]  acc;
    logic [WCNT_W-1:0] wcnt;
    logic              ovf;
    logic [WORD_W-1:0] word;
    logic [PC_W-1:0]   pc;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  sat_sum;
    logic              sat;
    logic              acc_en;
    logic              close;

    // Gate the word so X on an idle bus never reaches the adder.
    assign word = in_valid ? in_data : '0;

    popcount_frame_acc_onescount u_ones (
        .data  (word),
        .count (pc)
    );

    assign in_ready = !out_valid | out_ready;
    assign acc_en   = in_valid & in_ready;
    assign sum      = {1'b0, acc} + (ACC_W + 1)'(pc);
    assign sat      = sum > SAT_MAX;
    assign sat_sum  = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign close    = acc_en & (in_last | (wcnt == LAST_IDX));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            wcnt <= '0;
            ovf  <= 1'b0;
        end else if (close) begin
            acc  <= '0;
            wcnt <= '0;
            ovf  <= 1'b0;
        end else if (acc_en) begin
            acc  <= sat_sum;
            wcnt <= wcnt + WCNT_W'(1);
            ovf  <= ovf | sat;
        end
    end

    // A close reloads the buffer even while it drains, so no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_words    <= '0;
            out_overflow <= 1'b0;
        end else if (close) begin
            out_valid    <= 1'b1;
            out_count    <= sat_sum;
            out_words    <= OUT_WORDS_W'(wcnt) + OUT_WORDS_W'(1);
            out_overflow <= ovf | sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Directed bench: two instances (ACC_W=7 and ACC_W=5) in lockstep,
// frame results checked from a scoreboard queue.
module tb_popcount_frame_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       rdy7, vld7, ovf7;
    logic [6:0] cnt7;
    logic [7:0] wrd7;
    logic       rdy5, vld5, ovf5;
    logic [4:0] cnt5;
    logic [7:0] wrd5;

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        int c7;
        int c5;
        int w;
        int o7;
        int o5;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    popcount_frame_acc #(.MAX_WORDS(16), .ACC_W(7)) dut7 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (rdy7),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (vld7),
        .out_ready    (out_ready),
        .out_count    (cnt7),
        .out_words    (wrd7),
        .out_overflow (ovf7)
    );

    popcount_frame_acc #(.MAX_WORDS(16), .ACC_W(5)) dut5 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (rdy5),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (vld5),
        .out_ready    (out_ready),
        .out_count    (cnt5),
        .out_words    (wrd5),
        .out_overflow (ovf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c7, input int c5, input int w,
                        input int o7, input int o5);
        exp_t e;
        e.c7 = c7;
        e.c5 = c5;
        e.w  = w;
        e.o7 = o7;
        e.o5 = o5;
        q.push_back(e);
    endtask

    // Result leaves at the posedge following a negedge with valid&ready.
    always @(negedge clk) begin
        if (!rst && vld7 && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(vld7), 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("count7", 32'(cnt7), 32'(e.c7));
                chk("words7", 32'(wrd7), 32'(e.w));
                chk("ovf7", 32'(ovf7), 32'(e.o7));
                chk("valid5", 32'(vld5), 32'h1);
                chk("count5", 32'(cnt5), 32'(e.c5));
                chk("words5", 32'(wrd5), 32'(e.w));
                chk("ovf5", 32'(ovf5), 32'(e.o5));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [6:0] d, input logic l, input int strict);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        if (strict > 0) chk("b2b_in_ready", 32'(rdy7), 32'h1);
        if (strict > 1) chk("b2b_out_valid", 32'(vld7), 32'h1);
        while (!rdy7 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(vld7), 32'h0);
        chk("rst_count", 32'(cnt7), 32'h0);
        chk("rst_words", 32'(wrd7), 32'h0);
        chk("rst_ovf", 32'(ovf7), 32'h0);
        chk("rst_ready", 32'(rdy7), 32'h1);
        chk("rst_valid5", 32'(vld5), 32'h0);
        @(posedge clk);
        #1;

        // Basic three-word frame.
        push(8, 8, 3, 0, 0);
        send(7'h7F, 1'b0, 0);
        send(7'h01, 1'b0, 0);
        chk("latency_pre", 32'(vld7), 32'h0);
        send(7'h00, 1'b1, 0);
        chk("latency_post", 32'(vld7), 32'h1);
        idle(2);

        // Forced close after 16 words, then a fresh frame.
        push(64, 31, 16, 0, 1);
        for (int i = 0; i < 16; i++) send(7'h55, 1'b0, 0);
        chk("forced_valid", 32'(vld7), 32'h1);
        push(2, 2, 1, 0, 0);
        send(7'h03, 1'b1, 0);
        idle(2);

        // Saturation on the narrow instance, cleared next frame.
        push(35, 31, 5, 0, 1);
        for (int i = 0; i < 5; i++) send(7'h7F, i == 4, 0);
        push(2, 2, 1, 0, 0);
        send(7'h03, 1'b1, 0);
        idle(3);

        // Backpressure: hold the result with a word pending.
        out_ready = 1'b0;
        push(8, 8, 3, 0, 0);
        send(7'h7F, 1'b0, 0);
        send(7'h01, 1'b0, 0);
        send(7'h00, 1'b1, 0);
        in_valid = 1'b1;
        in_data  = 7'h0F;
        in_last  = 1'b1;
        push(4, 4, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(rdy7), 32'h0);
            chk("hold_valid", 32'(vld7), 32'h1);
            chk("hold_count", 32'(cnt7), 32'h8);
            chk("hold_words", 32'(wrd7), 32'h3);
            chk("hold_ovf", 32'(ovf7), 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_ready", 32'(rdy7), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
        chk("drain_close_valid", 32'(vld7), 32'h1);
        idle(3);

        // Reset mid-frame discards the partial sum.
        for (int i = 0; i < 3; i++) send(7'h7F, 1'b0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(rdy7), 32'h1);
        chk("midrst_valid", 32'(vld7), 32'h0);
        @(posedge clk);
        #1;
        push(1, 1, 1, 0, 0);
        send(7'h01, 1'b1, 0);
        idle(2);

        // Back-to-back single-word frames.
        push(1, 1, 1, 0, 0);
        send(7'h01, 1'b1, 1);
        push(2, 2, 1, 0, 0);
        send(7'h03, 1'b1, 2);
        push(3, 3, 1, 0, 0);
        send(7'h07, 1'b1, 2);
        chk("b2b_last_valid", 32'(vld7), 32'h1);

        t = 0;
        while (q.size() != 0 && t < 100) begin
            t++;
            @(posedge clk);
        end
        chk("queue_drained", 32'(q.size()), 32'h0);
        idle(2);
        chk("final_idle", 32'(vld7), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/popcount_frame_acc.md
Name: popcount_frame_acc

Overview:
- Streaming stage directly downstream of the 7-bit combinational ones counter.
- Accepts 7-bit words over a valid/ready handshake and counts the ones in each word.
- Accumulates those per-word counts across a frame, which ends on in_last or after MAX_WORDS words.
- Presents one registered frame total, a word count and an overflow flag on a valid/ready output.

Parameters:
- MAX_WORDS, 16, words after which a frame is force-closed without in_last (range 1..255).
- ACC_W, 7, accumulator and out_count width; the sum saturates at 2^ACC_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data and in_last are valid.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  7  word to count.
- in_last  in  1  final word of the frame.
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer takes the result.
- out_count  out  ACC_W  total ones in the frame, saturated.
- out_words  out  8  words in the frame (1..MAX_WORDS).
- out_overflow  out  1  saturation occurred in the frame.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, out_count=0, out_words=0, out_overflow=0, acc=0, wcnt=0, ovf=0.
- Combinational path: in_ready = !out_valid | out_ready. This is a single-entry output buffer with a same-cycle drain.
- Accept condition: acc_en = in_valid & in_ready.
- Per-word count: pc = number of ones in in_data (0..7), combinational, zero-extended to ACC_W+1 bits.
- Sum: sum = acc + pc, computed at ACC_W+1 bits. When sum > 2^ACC_W-1, sat_sum = 2^ACC_W-1 and sat = 1; otherwise sat_sum = sum and sat = 0.
- Frame close: close = acc_en & (in_last | wcnt == MAX_WORDS-1).
- On acc_en without close: acc <= sat_sum, ovf <= ovf|sat, wcnt <= wcnt+1.
- On close:
  - out_count <= sat_sum, out_words <= wcnt+1, out_overflow <= ovf|sat, out_valid <= 1.
  - acc <= 0, wcnt <= 0, ovf <= 0.
- On out_valid & out_ready without close: out_valid <= 0; out_count, out_words and out_overflow keep their values.
- Simultaneous drain and close: the output registers reload with the new frame and out_valid stays 1. No bubble and no lost result.
- Latency: the result is visible one cycle after the closing word is accepted. Sustained throughput is 1 word/clk while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, in_ready=0 and no word is accepted, including a word inside an open frame.
  - acc and wcnt hold.
  - out_* must stay stable until the handshake completes.
- Frame state: state is implied by (out_valid, wcnt).
  - IDLE: wcnt=0, out_valid=0.
  - ACCUM: wcnt>0.
  - HOLD: out_valid=1. HOLD coexists with IDLE/ACCUM only when drained in the same cycle; otherwise input is stalled.
- Single-word frame: in_last on the first word gives out_words=1 and out_count=pc.
- MAX_WORDS=1: every accepted word closes its own frame.
- in_last coinciding with wcnt==MAX_WORDS-1: exactly one close, out_words=MAX_WORDS.
- in_data, in_last and out_ready are ignored unless the matching valid is asserted. X on in_data while in_valid=0 must not propagate.
- rst mid-frame or while out_valid=1: the partial frame and the held result are discarded. in_ready=1 in the cycle after reset.
- Width checks: elaboration asserts MAX_WORDS <= 255 and ACC_W >= 3.

Decomposition:
- Shared package holds:
  - WORD_W=7, PC_W=3.
  - OUT_WORDS_W=8.
  - A function clog2 for sizing wcnt (WCNT_W = clog2(MAX_WORDS+1)).
- One sub-module is natural: the existing 7-bit combinational ones counter (onescount), instantiated once on in_data, producing pc.
- The accumulator, saturation, word counter and output buffer stay in this module.

Test Plan:
- rst=1 for 2 cycles, then released -> all outputs 0, in_ready=1. Reset then asserted mid-frame after 3 words -> next frame starts at out_words=1.
- Words 7'h7F, 7'h01, 7'h00(last), out_ready=1 -> out_valid one cycle after last, out_count=8, out_words=3, out_overflow=0.
- 16 words of 7'h55 with no in_last, MAX_WORDS=16 -> forced close, out_count=64, out_words=16. Next word starts a new frame.
- ACC_W=5, five words 7'h7F with last on the fifth -> out_count=31, out_overflow=1. The following frame (7'h03, last) gives out_count=2, out_overflow=0.
- out_ready=0 while result held -> in_ready=0, out_* stable for 10 cycles. Then out_ready=1 -> result drained and input resumes.
- Back-to-back single-word frames (in_last=1 every cycle) with out_ready=1:
  - Data 7'h01, 7'h03, 7'h07 -> out_count 1, 2, 3 on consecutive cycles, out_valid continuously 1.
  - in_ready never drops.
